pb_debounce_array: RTL and testbench

//  Parametrised N-channel push-button debouncer for the game-pad inputs (move keys, bomb key).
//  One shared tick prescaler, a 2-FF synchroniser and a consecutive-sample stability counter per channel.

---
 rtl/pb_debounce_array.sv | 137 +++++++++++++
 tb/tb_pb_debounce_array.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pb_debounce_array.sv
// rtl/pb_debounce_array.sv - N-channel push-button debouncer with press/release/fire strobes
//
// Purpose: debounce N_CH raw button pins using one shared sample-tick prescaler,
// a 2-FF synchroniser and a consecutive-sample stability counter per channel.
// Each channel yields a debounced level, one-clk press/release strobes and a
// fire strobe that optionally auto-repeats while the button is held.
//
// Ports:
//   i_clk          system clock
//   i_rst_n        synchronous reset, active low
//   i_btn_in       raw asynchronous button pins          [N_CH]
//   o_btn_level    debounced level, 1 = pressed           [N_CH]
//   o_btn_press    1-clk strobe on debounced 0->1         [N_CH]
//   o_btn_release  1-clk strobe on debounced 1->0         [N_CH]
//   o_btn_fire     1-clk strobe: press or repeat event    [N_CH]
//   o_tick         1-clk sample strobe shared by all channels

module pb_debounce_array #(
    parameter int N_CH         = 5,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 8,
    parameter int ACTIVE_LOW   = 0,
    parameter int REPEAT_EN    = 1,
    parameter int REPEAT_DELAY = 400,
    parameter int REPEAT_RATE  = 100
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [N_CH-1:0] i_btn_in,
    output logic [N_CH-1:0] o_btn_level,
    output logic [N_CH-1:0] o_btn_press,
    output logic [N_CH-1:0] o_btn_release,
    output logic [N_CH-1:0] o_btn_fire,
    output logic            o_tick
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = $clog2(STABLE_TICKS + 1);
    localparam int HW = $clog2(REPEAT_DELAY + 1);

    localparam logic [N_CH-1:0] POL         = (ACTIVE_LOW != 0) ? {N_CH{1'b1}} : {N_CH{1'b0}};
    localparam logic [TW-1:0]   TCNT_MAX    = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0]   TCNT_PRE    = TW'(TICK_DIV - 2);
    localparam logic [SW-1:0]   SCNT_MAX    = SW'(STABLE_TICKS - 1);
    localparam logic [HW-1:0]   HCNT_MAX    = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0]   HCNT_RELOAD = HW'(REPEAT_DELAY - REPEAT_RATE);

    logic [TW-1:0]   r_tcnt;
    logic            r_tick;
    logic [N_CH-1:0] r_sync1;
    logic [N_CH-1:0] r_sync2;
    logic [N_CH-1:0] w_s;

    // The tick flag is registered one count early so that it is high exactly
    // while the counter sits at its terminal value.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_tcnt <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tcnt <= (r_tcnt == TCNT_MAX) ? '0 : r_tcnt + 1'b1;
            r_tick <= (r_tcnt == TCNT_PRE);
        end
    end

    // Synchroniser holds raw pin polarity; resetting to the idle pin level
    // keeps an active-low released pin from briefly reading as pressed.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1 <= POL;
            r_sync2 <= POL;
        end else begin
            r_sync1 <= i_btn_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s    = r_sync2 ^ POL;
    assign o_tick = r_tick;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [SW-1:0] r_scnt;
        logic [HW-1:0] r_hcnt;
        logic          r_level;
        logic          r_press;
        logic          r_release;
        logic          r_fire;
        logic          w_differ;
        logic          w_flip;
        logic          w_rep;

        assign w_differ = (w_s[g] != r_level);
        assign w_flip   = r_tick && w_differ && (r_scnt == SCNT_MAX);
        // A release landing on a due repeat suppresses the repeat.
        assign w_rep    = (REPEAT_EN != 0) && r_tick && r_level && !w_flip && (r_hcnt == HCNT_MAX);

        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                r_scnt    <= '0;
                r_hcnt    <= '0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_fire    <= 1'b0;
            end else begin
                r_press   <= w_flip && w_s[g];
                r_release <= w_flip && !w_s[g];
                r_fire    <= (w_flip && w_s[g]) || w_rep;

                if (r_tick) begin
                    if (!w_differ) begin
                        r_scnt <= '0;
                    end else if (w_flip) begin
                        r_scnt  <= '0;
                        r_level <= w_s[g];
                    end else begin
                        r_scnt <= r_scnt + 1'b1;
                    end
                end

                // Hold counter idles at 0 while released, so a press always
                // starts the repeat delay from zero; any flip also clears it.
                if ((REPEAT_EN == 0) || w_flip || !r_level) begin
                    r_hcnt <= '0;
                end else if (r_tick) begin
                    r_hcnt <= w_rep ? HCNT_RELOAD : r_hcnt + 1'b1;
                end
            end
        end

        assign o_btn_level[g]   = r_level;
        assign o_btn_press[g]   = r_press;
        assign o_btn_release[g] = r_release;
        assign o_btn_fire[g]    = r_fire;
    end

endmodule

// File: tb/tb_pb_debounce_array.sv
// tb/tb_pb_debounce_array.sv - scoreboard bench for pb_debounce_array

module tb_pb_debounce_array;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] btn;
    logic [4:0] level, press, rel, fire;
    logic       tick;

    logic       al_btn;
    logic       al_level, al_press, al_rel, al_fire, al_tick;

    int  cyc    = 0;
    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 1'b0;

    typedef struct packed {
        int         cyc;
        logic [4:0] press;
        logic [4:0] rel;
        logic [4:0] fire;
        logic [4:0] level;
    } ev_t;

    ev_t q[$];
    ev_t qa[$];
    ev_t m_act, m_exp;
    logic m_tick_exp;

    always #5 clk = ~clk;

    pb_debounce_array #(
        .N_CH(5), .TICK_DIV(4), .STABLE_TICKS(3), .ACTIVE_LOW(0),
        .REPEAT_EN(1), .REPEAT_DELAY(5), .REPEAT_RATE(2)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_btn_in(btn),
        .o_btn_level(level), .o_btn_press(press), .o_btn_release(rel),
        .o_btn_fire(fire), .o_tick(tick)
    );

    pb_debounce_array #(
        .N_CH(1), .TICK_DIV(4), .STABLE_TICKS(3), .ACTIVE_LOW(1),
        .REPEAT_EN(0), .REPEAT_DELAY(5), .REPEAT_RATE(2)
    ) dut_al (
        .i_clk(clk), .i_rst_n(rst_n), .i_btn_in(al_btn),
        .o_btn_level(al_level), .o_btn_press(al_press), .o_btn_release(al_rel),
        .o_btn_fire(al_fire), .o_tick(al_tick)
    );

    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic exp_ev(input int c, input logic [4:0] p, input logic [4:0] r,
                          input logic [4:0] f, input logic [4:0] l);
        ev_t e;
        e.cyc = c; e.press = p; e.rel = r; e.fire = f; e.level = l;
        q.push_back(e);
    endtask

    task automatic exp_al(input int c, input logic p, input logic r,
                          input logic f, input logic l);
        ev_t e;
        e.cyc = c; e.press = {4'b0, p}; e.rel = {4'b0, r}; e.fire = {4'b0, f}; e.level = {4'b0, l};
        qa.push_back(e);
    endtask

    task automatic wait_to(input int n);
        int guard = 0;
        while (cyc < n && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if ({level, press, rel, fire, tick} !== 21'b0 ||
            {al_level, al_press, al_rel, al_fire, al_tick} !== 5'b0) begin
            errors++;
            $display("FAIL %s got lvl=%h p=%h r=%h f=%h t=%b al=%b%b%b%b%b want all 0",
                     name, level, press, rel, fire, tick,
                     al_level, al_press, al_rel, al_fire, al_tick);
        end
    endtask

    // Monitor: every strobe observed is matched against the next scoreboard entry.
    always @(negedge clk) begin
        if (mon_en) begin
            m_tick_exp = (cyc % 4 == 3);
            checks++;
            if (tick !== m_tick_exp || al_tick !== m_tick_exp) begin
                errors++;
                $display("FAIL tick cyc=%0d got %b/%b want %b", cyc, tick, al_tick, m_tick_exp);
            end
            if (|{press, rel, fire}) begin
                m_act = '{cyc, press, rel, fire, level};
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe cyc=%0d p=%h r=%h f=%h l=%h want none",
                             cyc, press, rel, fire, level);
                end else begin
                    m_exp = q.pop_front();
                    if (m_act !== m_exp) begin
                        errors++;
                        $display("FAIL event got cyc=%0d p=%h r=%h f=%h l=%h want cyc=%0d p=%h r=%h f=%h l=%h",
                                 m_act.cyc, m_act.press, m_act.rel, m_act.fire, m_act.level,
                                 m_exp.cyc, m_exp.press, m_exp.rel, m_exp.fire, m_exp.level);
                    end
                end
            end
            if (|{al_press, al_rel, al_fire}) begin
                m_act = '{cyc, {4'b0, al_press}, {4'b0, al_rel}, {4'b0, al_fire}, {4'b0, al_level}};
                checks++;
                if (qa.size() == 0) begin
                    errors++;
                    $display("FAIL al_unexpected_strobe cyc=%0d p=%b r=%b f=%b want none",
                             cyc, al_press, al_rel, al_fire);
                end else begin
                    m_exp = qa.pop_front();
                    if (m_act !== m_exp) begin
                        errors++;
                        $display("FAIL al_event got cyc=%0d p=%b r=%b f=%b l=%b want cyc=%0d p=%b r=%b f=%b l=%b",
                                 m_act.cyc, m_act.press[0], m_act.rel[0], m_act.fire[0], m_act.level[0],
                                 m_exp.cyc, m_exp.press[0], m_exp.rel[0], m_exp.fire[0], m_exp.level[0]);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n  = 1'b0;
        btn    = 5'h1F;
        al_btn = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset_state");
        mon_en = 1'b1;
        rst_n  = 1'b1;

        // All buttons held through reset qualify together.
        exp_ev(12, 5'h1F, 5'h00, 5'h1F, 5'h1F);
        wait_to(12); btn = 5'h00;
        exp_ev(24, 5'h00, 5'h1F, 5'h00, 5'h00);

        // Two-tick glitch on ch0 is absorbed.
        wait_to(28); btn[0] = 1'b1;
        wait_to(34); btn[0] = 1'b0;
        wait_to(48);
        checks++;
        if (level !== 5'h00) begin
            errors++;
            $display("FAIL glitch_level got %h want 00", level);
        end

        // Three-tick pulse on ch0 qualifies.
        btn[0] = 1'b1;
        exp_ev(60, 5'h01, 5'h00, 5'h01, 5'h01);
        wait_to(62); btn[0] = 1'b0;
        exp_ev(76, 5'h00, 5'h01, 5'h00, 5'h00);

        // Bounce on ch1 every 3 clk, then settle high.
        for (int k = 0; k < 14; k++) begin
            wait_to(80 + 3 * k);
            btn[1] = (k % 2 == 0);
        end
        wait_to(122);
        checks++;
        if (level[1] !== 1'b0) begin
            errors++;
            $display("FAIL bounce_level got %b want 0", level[1]);
        end
        btn[1] = 1'b1;
        exp_ev(136, 5'h02, 5'h00, 5'h02, 5'h02);
        wait_to(138); btn[1] = 1'b0;
        exp_ev(152, 5'h00, 5'h02, 5'h00, 5'h00);

        // Auto-repeat on ch2: +5 ticks, then every 2 ticks.
        wait_to(156); btn[2] = 1'b1;
        exp_ev(168, 5'h04, 5'h00, 5'h04, 5'h04);
        for (int k = 5; k <= 19; k += 2)
            exp_ev(168 + 4 * k, 5'h00, 5'h00, 5'h04, 5'h04);
        wait_to(236); btn[2] = 1'b0;
        exp_ev(248, 5'h00, 5'h04, 5'h00, 5'h00);

        // Release on the same tick a repeat is due: release only, no fire.
        wait_to(252); btn[3] = 1'b1;
        exp_ev(264, 5'h08, 5'h00, 5'h08, 5'h08);
        wait_to(272); btn[3] = 1'b0;
        exp_ev(284, 5'h00, 5'h08, 5'h00, 5'h00);

        // Simultaneous press on ch0 and ch3.
        wait_to(288); btn = btn | 5'b01001;
        exp_ev(300, 5'h09, 5'h00, 5'h09, 5'h09);
        wait_to(302); btn[0] = 1'b0; btn[3] = 1'b0;
        exp_ev(316, 5'h00, 5'h09, 5'h00, 5'h00);

        // Active-low instance, repeat disabled: held 10 ticks, fire only at press.
        wait_to(320); al_btn = 1'b0;
        exp_al(332, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_to(360); al_btn = 1'b1;
        exp_al(372, 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset while ch2 is repeating.
        wait_to(376); btn[2] = 1'b1;
        exp_ev(388, 5'h04, 5'h00, 5'h04, 5'h04);
        exp_ev(408, 5'h00, 5'h00, 5'h04, 5'h04);
        exp_ev(416, 5'h00, 5'h00, 5'h04, 5'h04);
        wait_to(418); rst_n = 1'b0;
        @(negedge clk);
        check_idle("reset_mid_hold");
        rst_n = 1'b1;
        exp_ev(12, 5'h04, 5'h00, 5'h04, 5'h04);
        wait_to(14); btn[2] = 1'b0;
        exp_ev(28, 5'h00, 5'h04, 5'h00, 5'h00);

        n = 0;
        while ((q.size() != 0 || qa.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0 || qa.size() != 0) begin
            errors++;
            $display("FAIL pending_events got %0d/%0d outstanding want 0", q.size(), qa.size());
        end
        repeat (40) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
